// File: rtl/pc_lut_writer.sv
// Purpose : writable 16-entry branch-target table with a combinational lookup port for fetch.
// Latency : single write visible on target 1 cycle after handshake; N-beat burst = N+1 cycles + 1 DONE cycle.
// Backpres: wr_ready low while load_start is pulsed in IDLE and throughout DONE; wr_data held while stalled.
// Option  : define PC_LUT_RELATIVE_EN to treat entries as signed PC-relative offsets (target = pc + entry).
module pc_lut_writer #(
    parameter int D     = 10,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [3:0]   wr_addr,
    input  logic [D-1:0] wr_data,
    input  logic         load_start,
    input  logic [3:0]   load_base,
    input  logic [4:0]   load_len,
    output logic         load_done,
    output logic         busy,
    input  logic         clear,
    input  logic [3:0]   rd_addr,
    input  logic [D-1:0] pc,
    output logic [D-1:0] target,
    output logic         target_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         ptr_q, ptr_d;
    logic [4:0]         count_q, count_d;
    logic [D-1:0]       data_q [DEPTH];
    logic [DEPTH-1:0]   valid_q, valid_d;

    logic               wr_en;
    logic [3:0]         wr_idx;
    logic [4:0]         len_eff;

    // Lengths beyond the table size would rewrite entries; cap at one full pass.
    assign len_eff = (load_len > 5'd16) ? 5'd16 : load_len;

    // A beat lands on the handshake; bursts address through ptr, singles through wr_addr.
    assign wr_en  = wr_valid && wr_ready;
    assign wr_idx = (state_q == S_LOAD) ? ptr_q : wr_addr;

    // State register and burst bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 4'd0;
            count_q <= 5'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: start a burst, count beats down, pulse DONE for one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d = (len_eff == 5'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (wr_en && (count_q == 5'd1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: load_start in IDLE steals the cycle so a same-cycle beat is refused.
    always_comb begin
        wr_ready  = ((state_q == S_IDLE) && !load_start) || (state_q == S_LOAD);
        load_done = (state_q == S_DONE);
        busy      = (state_q == S_LOAD) || (state_q == S_DONE);
    end

    // Burst pointer wraps naturally at 4 bits; count tracks remaining beats.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if ((state_q == S_IDLE) && load_start && (len_eff != 5'd0)) begin
            ptr_d   = load_base;
            count_d = len_eff;
        end else if ((state_q == S_LOAD) && wr_en) begin
            ptr_d   = ptr_q + 4'd1;
            count_d = count_q - 5'd1;
        end
    end

    // Valid bits: clear only acts in IDLE, and a same-cycle write wins for its own entry.
    always_comb begin
        valid_d = valid_q;
        if ((state_q == S_IDLE) && clear) begin
            valid_d = '0;
        end
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    // Valid flag storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Target storage; clear leaves data in place, only the valid bits drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (wr_en) begin
            data_q[wr_idx] <= wr_data;
        end
    end

    // Lookup reads the registered table only, so a write shows up the cycle after it lands.
`ifdef PC_LUT_RELATIVE_EN
    always_comb begin
        target       = pc + data_q[rd_addr];
        target_valid = valid_q[rd_addr];
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;

    always_comb begin
        target       = data_q[rd_addr];
        target_valid = valid_q[rd_addr];
    end
`endif

endmodule

// File: tb/tb_pc_lut_writer.sv
// Purpose : self-checking bench for pc_lut_writer: vector table for single writes, scoreboard for table contents.
// Latency : expected lookups queued as stimulus is driven and drained through rd_addr afterwards.
// Backpres: bursts exercise wr_valid gaps, the refused beat on load_start and wr_ready low in DONE.
module tb_pc_lut_writer;
    localparam int D = 10;

    logic         clk;
    logic         rst_n;
    logic         wr_valid;
    logic         wr_ready;
    logic [3:0]   wr_addr;
    logic [D-1:0] wr_data;
    logic         load_start;
    logic [3:0]   load_base;
    logic [4:0]   load_len;
    logic         load_done;
    logic         busy;
    logic         clear;
    logic [3:0]   rd_addr;
    logic [D-1:0] pc;
    logic [D-1:0] target;
    logic         target_valid;

    pc_lut_writer #(.D(D), .DEPTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .load_start   (load_start),
        .load_base    (load_base),
        .load_len     (load_len),
        .load_done    (load_done),
        .busy         (busy),
        .clear        (clear),
        .rd_addr      (rd_addr),
        .pc           (pc),
        .target       (target),
        .target_valid (target_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   addr;
        logic [D-1:0] tgt;
        logic         vld;
    } exp_t;

    typedef struct {
        logic [3:0]   addr;
        logic [D-1:0] data;
        logic [3:0]   probe;
        logic [D-1:0] probe_tgt;
        logic         probe_vld;
    } vec_t;

    exp_t         sbq[$];
    vec_t         vecs[4];
    logic [D-1:0] m_data[16];
    logic         m_valid[16];
    int           checks   = 0;
    int           errors   = 0;
    int           done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n && load_done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: sim still running, expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] a);
        exp_t e;
        e.addr = a;
`ifdef PC_LUT_RELATIVE_EN
        e.tgt  = pc + m_data[a];
`else
        e.tgt  = m_data[a];
`endif
        e.vld  = m_valid[a];
        sbq.push_back(e);
    endtask

    task automatic push_all();
        for (int i = 0; i < 16; i++) push_exp(4'(i));
    endtask

    task automatic drain(input string nm);
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rd_addr = e.addr;
            #1;
            chk($sformatf("%s_tgt[%0d]", nm, e.addr), target, e.tgt);
            chk($sformatf("%s_vld[%0d]", nm, e.addr), target_valid, e.vld);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
        end
    endtask

    task automatic single_write(input logic [3:0] a, input logic [D-1:0] d);
        int n;
        step();
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        rd_addr  = a;
        #1;
        n = 0;
        while (!wr_ready && n < 20) begin
            step();
            n++;
        end
        chk("single_wr_ready", wr_ready, 1);
        chk("single_no_bypass", target_valid, m_valid[a]);
        step();
        wr_valid   = 1'b0;
        m_data[a]  = d;
        m_valid[a] = 1'b1;
        push_exp(a);
    endtask

    task automatic burst(input logic [3:0] base, input logic [4:0] len, input logic [D-1:0] d0,
                         input bit gaps, input bit clr_in_gap);
        int n;
        int start_cnt;
        n = (len > 5'd16) ? 16 : int'(len);
        step();
        start_cnt  = done_cnt;
        load_start = 1'b1;
        load_base  = base;
        load_len   = len;
        wr_valid   = 1'b1;
        wr_addr    = base + 4'd8;
        wr_data    = 10'h155;
        #1;
        chk("start_wr_ready", wr_ready, 0);
        chk("start_busy", busy, 0);
        step();
        load_start = 1'b0;
        wr_valid   = 1'b0;
        #1;
        chk("burst_busy_after_start", busy, 1);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) begin
                wr_valid = 1'b0;
                clear    = clr_in_gap;
                #1;
                chk("gap_load_done", load_done, 0);
                step();
                clear = 1'b0;
            end
            wr_valid = 1'b1;
            wr_data  = d0 + D'(i);
            #1;
            chk("beat_wr_ready", wr_ready, 1);
            step();
            m_data[(int'(base) + i) % 16]  = d0 + D'(i);
            m_valid[(int'(base) + i) % 16] = 1'b1;
        end
        wr_valid = 1'b0;
        #1;
        chk("done_pulse", load_done, 1);
        chk("done_busy", busy, 1);
        chk("done_wr_ready", wr_ready, 0);
        step();
        chk("after_done_pulse", load_done, 0);
        chk("after_done_busy", busy, 0);
        step();
        chk("done_pulse_count", done_cnt - start_cnt, 1);
    endtask

    initial begin
        rst_n      = 1'b1;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        load_start = 1'b0;
        load_base  = '0;
        load_len   = '0;
        clear      = 1'b0;
        rd_addr    = '0;
        pc         = '0;
        model_reset();

        vecs[0] = '{addr: 4'd1,  data: 10'd11,  probe: 4'd1, probe_tgt: 10'd11, probe_vld: 1'b1};
        vecs[1] = '{addr: 4'd2,  data: 10'd41,  probe: 4'd3, probe_tgt: 10'd0,  probe_vld: 1'b0};
        vecs[2] = '{addr: 4'd9,  data: 10'h3FF, probe: 4'd1, probe_tgt: 10'd11, probe_vld: 1'b1};
        vecs[3] = '{addr: 4'd15, data: 10'd512, probe: 4'd2, probe_tgt: 10'd41, probe_vld: 1'b1};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_load_done", load_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_target", target, 0);
        chk("rst_target_valid", target_valid, 0);
        #20;
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_release_wr_ready", wr_ready, 1);
        push_all();
        drain("after_reset");

        // Single writes from the vector table
        for (int v = 0; v < 4; v++) begin
            single_write(vecs[v].addr, vecs[v].data);
            drain("single");
            rd_addr = vecs[v].probe;
            #1;
            chk($sformatf("vec%0d_probe_tgt", v), target, vecs[v].probe_tgt);
            chk($sformatf("vec%0d_probe_vld", v), target_valid, vecs[v].probe_vld);
        end

        // Burst with wrap, back-pressure and an ignored clear
        burst(4'd14, 5'd4, 10'd100, 1'b1, 1'b1);
        push_all();
        drain("burst_wrap");

        // Zero-length burst touches nothing
        burst(4'd3, 5'd0, 10'd0, 1'b0, 1'b0);
        push_all();
        drain("burst_len0");

        // Full-table burst, then an over-length burst that must clamp to 16
        burst(4'd5, 5'd16, 10'd200, 1'b0, 1'b0);
        push_all();
        drain("burst_len16");
        burst(4'd0, 5'd20, 10'd300, 1'b0, 1'b0);
        push_all();
        drain("burst_clamp");

        // Clear colliding with a single write
        step();
        clear    = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 4'd7;
        wr_data  = 10'd9;
        step();
        clear    = 1'b0;
        wr_valid = 1'b0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_data[7]  = 10'd9;
        m_valid[7] = 1'b1;
        push_all();
        drain("clear_collide");

        // Reset mid-burst aborts without load_done
        begin
            int cnt0;
            step();
            cnt0       = done_cnt;
            load_start = 1'b1;
            load_base  = 4'd0;
            load_len   = 5'd4;
            step();
            load_start = 1'b0;
            for (int i = 0; i < 2; i++) begin
                wr_valid = 1'b1;
                wr_data  = 10'd50 + 10'(i);
                step();
            end
            wr_valid = 1'b0;
            rd_addr  = 4'd0;
            #1 rst_n = 1'b0;
            #1;
            chk("abort_busy", busy, 0);
            chk("abort_load_done", load_done, 0);
            chk("abort_target", target, 0);
            chk("abort_target_valid", target_valid, 0);
            model_reset();
            step();
            step();
            rst_n = 1'b1;
            #1;
            chk("abort_release_wr_ready", wr_ready, 1);
            push_all();
            drain("abort");
            step();
            step();
            chk("abort_no_done", done_cnt - cnt0, 0);
            single_write(4'd6, 10'd77);
            drain("post_abort_write");
        end

`ifdef PC_LUT_RELATIVE_EN
        single_write(4'd0, 10'h3FB);
        single_write(4'd1, 10'h3FF);
        single_write(4'd2, 10'd1);
        drain("rel_load");
        pc = 10'h014; rd_addr = 4'd0; #1;
        chk("rel_neg5", target, 10'h00F);
        pc = 10'h000; rd_addr = 4'd1; #1;
        chk("rel_neg1", target, 10'h3FF);
        pc = 10'h3FF; rd_addr = 4'd2; #1;
        chk("rel_wrap", target, 10'h000);
        chk("rel_valid", target_valid, 1);
        pc = '0;
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_lut_writer.md
Name: pc_lut_writer

Overview:
- Writable branch-target table: the write side of the PC lookup interface that maps a 4-bit branch index to a D-bit jump target.
- Loaded at boot or by debug logic through a valid/ready write port, either single-entry or as an auto-incrementing burst.
- Drives a combinational lookup port (rd_addr -> target) to the fetch stage, with a per-entry valid flag.

Parameters:
D, 10, width of a stored target / program counter in bits.
DEPTH, 16, number of table entries; fixed to match the 4-bit index.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
wr_valid  input  1  write beat offered
wr_ready  output  1  write beat can be accepted
wr_addr  input  4  entry index for single writes; ignored during burst
wr_data  input  D  target value to store
load_start  input  1  one-cycle pulse: begin burst load
load_base  input  4  first index of burst
load_len  input  5  burst beat count, 0..16
load_done  output  1  one-cycle pulse after last burst beat stored
busy  output  1  burst in progress (state LOAD or DONE)
clear  input  1  invalidate all entries
rd_addr  input  4  lookup index
pc  input  D  current PC; used only with PC_LUT_RELATIVE_EN
target  output  D  lookup result
target_valid  output  1  entry rd_addr has been written since last clear/reset

Behaviour:
- Storage: DEPTH x D data registers plus DEPTH valid bits.
- Reset (async, rst_n=0): all data=0, all valid=0, state=IDLE, ptr=0, count=0.
- Outputs during and after reset: load_done=0, busy=0, target=0, target_valid=0, wr_ready=1 once rst_n is released.
- Reset asserted mid-burst aborts the burst. No load_done is issued.
- Handshake: a beat transfers on a rising edge with wr_valid && wr_ready. wr_data must be held stable while wr_valid=1 and wr_ready=0.
- wr_ready = (state==IDLE && !load_start) || state==LOAD. In the DONE state wr_ready is 0.
- FSM states: IDLE, LOAD, DONE.
- IDLE, load_start=1, load_len!=0: ptr<=load_base, count<=load_len, go to LOAD. A beat offered in the same cycle is not accepted.
- IDLE, load_start=1, load_len==0: go to DONE. No writes occur.
- IDLE, accepted beat: data[wr_addr]<=wr_data, valid[wr_addr]<=1.
- LOAD, accepted beat: data[ptr]<=wr_data, valid[ptr]<=1, ptr<=ptr+1 mod 16 (15 wraps to 0), count<=count-1.
- LOAD, beat accepted with count==1: go to DONE.
- LOAD: load_start is ignored.
- DONE: load_done=1 for exactly this cycle; next state IDLE.
- Burst lengths above 16 are clamped to 16. A 16-beat burst overwrites every entry exactly once.
- clear is honoured in IDLE only; it is ignored in LOAD and DONE.
- clear: all valid bits <=0 in one cycle; data is retained.
- clear and an accepted beat in the same IDLE cycle: the written entry ends valid=1, all others valid=0.
- Lookup is combinational from the registered table: target=data[rd_addr], target_valid=valid[rd_addr].
- No write-to-read bypass: a write becomes visible on target the cycle after its handshake.
- Latency: single write costs 1 cycle. A burst of N beats with no stalls costs N+1 cycles from load_start (LOAD) plus 1 cycle (DONE).

Optional Feature:
- Macro: PC_LUT_RELATIVE_EN.
- Defined: stored entries are signed D-bit PC-relative offsets, and target=(pc + data[rd_addr]) mod 2**D, i.e. the D-bit sum with carry discarded. Example for D=10: pc=4, entry=-1 (0x3FF) gives target=3.
- Defined: target_valid is unchanged, and target is still combinational from the registered table plus pc.
- Not defined: target=data[rd_addr] (absolute), and pc is ignored.

Test Plan:
- Reset then single writes: idx1=11, idx2=41 -> rd_addr=1 gives target=11, valid=1 on the cycle after the handshake; rd_addr=2 gives 41; rd_addr=3 gives target=0, valid=0.
- Burst with back-pressure: load_base=14, load_len=4, data 100,101,102,103 with wr_valid gaps -> entries 14,15,0,1 hold 100..103; load_done is a single pulse; busy=1 from the cycle after load_start until load_done inclusive; wr_ready=0 in DONE.
- Edge bursts: load_len=0 -> load_done pulse 1 cycle after load_start, no entry changes; load_len=16 from base 5 -> all 16 entries written and valid.
- Clear collision: all entries valid; in IDLE assert clear with a write of idx7=9 -> only idx7 valid (target 9); other entries still hold their old data with valid=0.
- Abort: rst_n low after 2 of 4 burst beats -> immediate IDLE, all valid=0, target=0; no load_done; a single write succeeds after release.
- PC_LUT_RELATIVE_EN (D=10): entry0=0x3FB (-5), pc=0x014 -> target=0x00F; entry1=0x3FF, pc=0x000 -> target=0x3FF; entry2=1, pc=0x3FF -> target=0 (wrap).
